qarctan_div_ctrl: RTL and testbench

- Quadrature-arctangent stage of the FM demodulator.
- Accepts one I/Q sample pair and forms the qarctan ratio operands.
- Drives the external serial unsigned divider through its start/done interface, consumes the quotient, and emits a signed phase angle in Q(BITS) radians.
- Sits directly upstream of the divider (it feeds it) and also consumes its result. It replaces any in-line divide in the demod path.

---
 rtl/qarctan_div_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_qarctan_div_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qarctan_div_ctrl.sv
// qarctan_div_ctrl: quadrature-arctangent stage of the FM demodulator.
// Takes one I/Q pair, forms the qarctan ratio operands, runs them through the
// external serial divider (start/done handshake) and emits a signed phase
// angle in Q(BITS) radians.
// Optional build macro: QARCTAN_DIFF_EN -- output the difference between
// successive angles (FM discriminator) instead of the raw angle.
module qarctan_div_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS           = 10,
  parameter int QUAD1          = 804,
  parameter int QUAD3          = 2412,
  parameter int DIVIDEND_WIDTH = 64,
  parameter int DIVISOR_WIDTH  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_x,
  input  logic [DATA_WIDTH-1:0]     in_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_angle,
  output logic                      out_err,
  output logic                      div_start,
  output logic [DIVIDEND_WIDTH-1:0] div_dividend,
  output logic [DIVISOR_WIDTH-1:0]  div_divisor,
  input  logic [DIVIDEND_WIDTH-1:0] div_quotient,
  input  logic                      div_done,
  input  logic                      div_overflow
);

  // Operand width: two guard bits so |y|+1 and x +/- abs_y never wrap.
  localparam int OW = DATA_WIDTH + 2;
  // Product width: signed quotient times a small pi/4 constant.
  localparam int PW = DIVIDEND_WIDTH + 34;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT, S_SCALE, S_OUT
  } state_t;

  state_t                      state_q;
  logic signed [DATA_WIDTH-1:0] x_q, y_q;
  logic signed [OW-1:0]        quad_q;
  logic                        neg_r_q, neg_y_q, ovf_q;
  logic [DIVIDEND_WIDTH-1:0]   quot_q;

  logic                        in_ready_q, out_valid_q, out_err_q, div_start_q;
  logic [DATA_WIDTH-1:0]       out_angle_q;
  logic [DIVIDEND_WIDTH-1:0]   div_dividend_q;
  logic [DIVISOR_WIDTH-1:0]    div_divisor_q;
`ifdef QARCTAN_DIFF_EN
  logic signed [DATA_WIDTH-1:0] prev_angle_q, raw_angle_q;
`endif

  // Next-value terms computed from the captured sample / quotient.
  logic signed [OW-1:0]             x_ext, y_ext, abs_y, num_d, den_d, quad_d, abs_num;
  logic [DIVIDEND_WIDTH-1:0]        dividend_d;
  logic [DIVISOR_WIDTH-1:0]         divisor_d;
  logic signed [DIVIDEND_WIDTH:0]   r_s;
  logic signed [PW-1:0]             prod, angle_full;
  logic signed [DATA_WIDTH-1:0]     angle_d, out_angle_d;

  // Operand formation (SETUP) and angle reconstruction (SCALE) datapath.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    num_d  = '0;
    den_d  = '0;
    quad_d = '0;
    x_ext  = OW'(x_q);
    y_ext  = OW'(y_q);
    abs_y  = ((y_ext < 0) ? -y_ext : y_ext) + OW'(1);
    if (!x_q[DATA_WIDTH-1]) begin
      num_d  = x_ext - abs_y;
      den_d  = x_ext + abs_y;
      quad_d = OW'(QUAD1);
    end else begin
      num_d  = x_ext + abs_y;
      den_d  = abs_y - x_ext;
      quad_d = OW'(QUAD3);
    end
    abs_num    = num_d[OW-1] ? -num_d : num_d;
    dividend_d = DIVIDEND_WIDTH'($unsigned(abs_num)) << BITS;
    divisor_d  = DIVISOR_WIDTH'($unsigned(den_d));

    // Signed ratio, scaled by pi/4 with a floor shift, folded into the quadrant.
    r_s        = neg_r_q ? -$signed({1'b0, quot_q}) : $signed({1'b0, quot_q});
    prod       = PW'(r_s) * PW'(QUAD1);
    angle_full = PW'(quad_q) - (prod >>> BITS);
    if (neg_y_q) angle_full = -angle_full;
    angle_d    = ovf_q ? '0 : DATA_WIDTH'(angle_full);
`ifdef QARCTAN_DIFF_EN
    out_angle_d = ovf_q ? '0 : angle_d - prev_angle_q;
`else
    out_angle_d = angle_d;
`endif
  end

  // Control FSM with registered handshake and divider outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q        <= S_IDLE;
      x_q            <= '0;
      y_q            <= '0;
      quad_q         <= '0;
      neg_r_q        <= 1'b0;
      neg_y_q        <= 1'b0;
      ovf_q          <= 1'b0;
      quot_q         <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_err_q      <= 1'b0;
      out_angle_q    <= '0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
`ifdef QARCTAN_DIFF_EN
      prev_angle_q   <= '0;
      raw_angle_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q        <= in_x;
            y_q        <= in_y;
            in_ready_q <= 1'b0;
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          quad_q         <= quad_d;
          neg_r_q        <= num_d[OW-1];
          neg_y_q        <= y_q[DATA_WIDTH-1];
          div_dividend_q <= dividend_d;
          div_divisor_q  <= divisor_d;
          div_start_q    <= 1'b1;
          state_q        <= S_START;
        end
        S_START: begin
          div_start_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            quot_q  <= div_quotient;
            ovf_q   <= div_overflow;
            state_q <= S_SCALE;
          end
        end
        S_SCALE: begin
          out_angle_q <= out_angle_d;
          out_err_q   <= ovf_q;
          out_valid_q <= 1'b1;
`ifdef QARCTAN_DIFF_EN
          raw_angle_q <= angle_d;
`endif
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef QARCTAN_DIFF_EN
            if (!out_err_q) prev_angle_q <= raw_angle_q;
`endif
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_angle    = out_angle_q;
  assign out_err      = out_err_q;
  assign div_start    = div_start_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_qarctan_div_ctrl.sv
// Bench for qarctan_div_ctrl: drives directed I/Q samples, models the
// external serial divider, and scores every emitted angle against a queue.
module tb_qarctan_div_ctrl;

  localparam int DW  = 32;
  localparam int DVW = 64;
  localparam int DSW = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid, in_ready;
  logic [DW-1:0]  in_x, in_y;
  logic           out_valid, out_ready;
  logic [DW-1:0]  out_angle;
  logic           out_err;
  logic           div_start;
  logic [DVW-1:0] div_dividend;
  logic [DSW-1:0] div_divisor;
  logic [DVW-1:0] div_quotient;
  logic           div_done, div_overflow;

  qarctan_div_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_angle    (out_angle),
    .out_err      (out_err),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_done     (div_done),
    .div_overflow (div_overflow)
  );

  always #5 clock = ~clock;

  // Serial divider model: done pulses 65 cycles after the start pulse.
  logic           busy, stray_req, force_ovf;
  int             cnt;
  logic [DVW-1:0] dvd;
  logic [DSW-1:0] dvs;

  always @(posedge clock) begin
    if (reset) begin
      busy         <= 1'b0;
      cnt          <= 0;
      dvd          <= '0;
      dvs          <= '0;
      div_done     <= 1'b0;
      div_overflow <= 1'b0;
      div_quotient <= '0;
    end else begin
      div_done     <= 1'b0;
      div_overflow <= 1'b0;
      if (stray_req && !busy) begin
        div_done     <= 1'b1;
        div_quotient <= 64'd12345;
      end else if (div_start && !busy) begin
        busy <= 1'b1;
        cnt  <= 63;
        dvd  <= div_dividend;
        dvs  <= div_divisor;
      end else if (busy) begin
        if (cnt == 0) begin
          busy     <= 1'b0;
          div_done <= 1'b1;
          if (dvs == '0 || force_ovf) begin
            div_overflow <= 1'b1;
            div_quotient <= '1;
          end else begin
            div_quotient <= dvd / DVW'(dvs);
          end
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  typedef struct {
    string         tag;
    logic [DW-1:0] angle;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
`ifdef QARCTAN_DIFF_EN
  int   prev_m = 0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Expected output for a sample whose undifferenced angle is raw.
  task automatic push_exp(input string tag, input int raw, input logic err);
    exp_t e;
    int   o;
    if (err) begin
      o = 0;
    end else begin
`ifdef QARCTAN_DIFF_EN
      o      = raw - prev_m;
      prev_m = raw;
`else
      o = raw;
`endif
    end
    e.tag   = tag;
    e.angle = DW'(o);
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic send(input string tag, input int x, input int y, input int raw, input logic err);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    force_ovf = err;
    push_exp(tag, raw, err);
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input int stall);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("out_valid_seen", 64'(out_valid), 64'd1);
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (out_valid && sb.size() != 0) begin
      e = sb.pop_front();
      for (int i = 0; i < stall; i++) begin
        check({e.tag, "_stall_valid"}, 64'(out_valid), 64'd1);
        check({e.tag, "_stall_angle"}, {32'b0, out_angle}, {32'b0, e.angle});
        check({e.tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
        @(posedge clock); #1;
      end
      check({e.tag, "_angle"}, {32'b0, out_angle}, {32'b0, e.angle});
      check({e.tag, "_err"}, 64'(out_err), 64'(e.err));
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check({e.tag, "_released"}, 64'(out_valid), 64'd0);
      check({e.tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    end
    force_ovf = 1'b0;
  endtask

  initial begin
    int st, ov, pulses;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    stray_req = 1'b0;
    force_ovf = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_angle", {32'b0, out_angle}, 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_div_start", 64'(div_start), 64'd0);
    check("rst_div_dividend", div_dividend, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // First sample: operands, start pulse timing and output latency.
    send("x1024_y0", 1024, 0, 2, 1'b0);
    st = -1; ov = -1; pulses = 0;
    for (int c = 1; c <= 120; c++) begin
      if (div_start) begin
        pulses++;
        if (st < 0) begin
          st = c;
          check("dividend", div_dividend, 64'd1047552);
          check("divisor", {32'b0, div_divisor}, 64'd1025);
        end
      end
      if (out_valid) begin
        ov = c;
        break;
      end
      @(posedge clock); #1;
    end
    check("start_cycle", 64'(st), 64'd2);
    check("start_pulses", 64'(pulses), 64'd1);
    check("out_valid_cycle", 64'(ov), 64'd69);
    expect_out(0);

    send("x0_y1024", 0, 1024, 1608, 1'b0);
    expect_out(0);
    send("x0_yn1024", 0, -1024, -1608, 1'b0);
    expect_out(0);
    send("xn1024_y0", -1024, 0, 3215, 1'b0);
    expect_out(0);
    send("x1024_y1024", 1024, 1024, 804, 1'b0);
    expect_out(0);

    // Consumer stalls for 10 cycles.
    send("stall", 1024, 0, 2, 1'b0);
    expect_out(10);

    // Divider reports overflow: zero angle with the error flag.
    send("ovf", 1024, 0, 0, 1'b1);
    expect_out(0);

    // Reset while waiting on the divider drops the pending sample.
    send("abort", 0, 1024, 1608, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
`ifdef QARCTAN_DIFF_EN
    prev_m = 0;
`endif
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    stray_req = 1'b1;
    @(posedge clock); #1;
    stray_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("stray_in_ready", 64'(in_ready), 64'd1);
    check("stray_out_valid", 64'(out_valid), 64'd0);
    check("stray_div_start", 64'(div_start), 64'd0);

    send("post_rst_x0_y1024", 0, 1024, 1608, 1'b0);
    expect_out(0);
    send("post_rst_xn1024_y0", -1024, 0, 3215, 1'b0);
    expect_out(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
